// File: rtl/corner_scan_ctrl_if.sv
// Purpose : bundles the scan controller's config, pixel-stream, detector and result signals.
// Latency : wires only; no logic lives in this interface.
// Backpr. : pixel stream uses pix_valid/pix_ready; the source holds pix_valid until pix_ready.
//
// Port summary (slave = controller side):
//   start, cfg_we/cfg_idx/cfg_rgb/cfg_thresh            control and config table writes
//   pix_valid/pix_ready, pix_r/g/b                      raster pixel stream
//   det_r/g/b, det_rgb_target, det_threshold, det_hit   time-shared corner_detect port
//   busy, frame_done, found, hit_x, hit_y               per-frame results
interface corner_scan_ctrl_if #(
    parameter int THRESH_W = 10
);
    logic                start;
    logic                cfg_we;
    logic [1:0]          cfg_idx;
    logic [23:0]         cfg_rgb;
    logic [THRESH_W-1:0] cfg_thresh;
    logic                pix_valid;
    logic                pix_ready;
    logic [7:0]          pix_r;
    logic [7:0]          pix_g;
    logic [7:0]          pix_b;
    logic [7:0]          det_r;
    logic [7:0]          det_g;
    logic [7:0]          det_b;
    logic [23:0]         det_rgb_target;
    logic [THRESH_W-1:0] det_threshold;
    logic                det_hit;
    logic                busy;
    logic                frame_done;
    logic [3:0]          found;
    logic [39:0]         hit_x;
    logic [39:0]         hit_y;

    modport master (
        output start, cfg_we, cfg_idx, cfg_rgb, cfg_thresh,
        output pix_valid, pix_r, pix_g, pix_b, det_hit,
        input  pix_ready, det_r, det_g, det_b, det_rgb_target, det_threshold,
        input  busy, frame_done, found, hit_x, hit_y
    );

    modport slave (
        input  start, cfg_we, cfg_idx, cfg_rgb, cfg_thresh,
        input  pix_valid, pix_r, pix_g, pix_b, det_hit,
        output pix_ready, det_r, det_g, det_b, det_rgb_target, det_threshold,
        output busy, frame_done, found, hit_x, hit_y
    );
endinterface

// File: rtl/corner_scan_ctrl.sv
// Purpose : time-shares one corner_detect across four colour targets and records first-match x/y per frame.
// Latency : 5 cycles per pixel (1 accept + 4 evaluate); frame_done one cycle after the last evaluation.
// Backpr. : pix_ready only in WAIT_PIX; the upstream holds pix_valid until accepted.
//
// Ports: clk_50 (rising edge), reset (sync, active high), bus (corner_scan_ctrl_if.slave).
module corner_scan_ctrl #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int THRESH_W = 10
) (
    input  logic              clk_50,
    input  logic              reset,
    corner_scan_ctrl_if.slave bus
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PIX,
        S_EVAL,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [23:0]         r_cfg_rgb [4];
    logic [THRESH_W-1:0] r_cfg_thr [4];
    logic [23:0]         r_sh_rgb  [4];
    logic [THRESH_W-1:0] r_sh_thr  [4];
    logic [23:0]         w_cfg_rgb_nxt [4];
    logic [THRESH_W-1:0] w_cfg_thr_nxt [4];

    logic [9:0]          r_x;
    logic [9:0]          r_y;
    logic [1:0]          r_slot;
    logic [23:0]         r_pix;
    logic [23:0]         r_det_tgt;
    logic [THRESH_W-1:0] r_det_thr;
    logic [3:0]          r_found;
    logic [9:0]          r_hit_x [4];
    logic [9:0]          r_hit_y [4];
    logic                r_busy;
    logic                r_frame_done;

    logic                w_start_acc;
    logic                w_last_slot;
    logic                w_last_pix;
    logic [23:0]         w_cur_tgt;
    logic [THRESH_W-1:0] w_cur_thr;

    // Config table with this cycle's write merged in, so a write coinciding
    // with start lands in the shadow copy as well.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cfg_rgb_nxt[i] = r_cfg_rgb[i];
            w_cfg_thr_nxt[i] = r_cfg_thr[i];
            if (bus.cfg_we && (bus.cfg_idx == 2'(i))) begin
                w_cfg_rgb_nxt[i] = bus.cfg_rgb;
                w_cfg_thr_nxt[i] = bus.cfg_thresh;
            end
        end
    end

    // Next state. busy is still high during the frame_done cycle, so a start
    // arriving there is ignored like any other start during a scan.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = bus.start && !r_busy &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));
        w_last_slot = (r_slot == 2'd3);
        w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
        case (r_state)
            S_IDLE:     if (w_start_acc) w_state_nxt = S_WAIT_PIX;
            S_WAIT_PIX: if (bus.pix_valid) w_state_nxt = S_EVAL;
            S_EVAL:     if (w_last_slot) w_state_nxt = w_last_pix ? S_DONE : S_WAIT_PIX;
            S_DONE:     if (w_start_acc) w_state_nxt = S_WAIT_PIX;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cur_tgt = r_sh_rgb[r_slot];
    assign w_cur_thr = r_sh_thr[r_slot];

    // The detector sees the live slot only in EVAL; elsewhere the last
    // evaluated target/threshold is held.
    assign bus.det_r          = r_pix[23:16];
    assign bus.det_g          = r_pix[15:8];
    assign bus.det_b          = r_pix[7:0];
    assign bus.det_rgb_target = (r_state == S_EVAL) ? w_cur_tgt : r_det_tgt;
    assign bus.det_threshold  = (r_state == S_EVAL) ? w_cur_thr : r_det_thr;

    assign bus.pix_ready  = (r_state == S_WAIT_PIX);
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.found      = r_found;
    assign bus.hit_x      = {r_hit_x[3], r_hit_x[2], r_hit_x[1], r_hit_x[0]};
    assign bus.hit_y      = {r_hit_y[3], r_hit_y[2], r_hit_y[1], r_hit_y[0]};

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_slot       <= '0;
            r_pix        <= '0;
            r_det_tgt    <= '0;
            r_det_thr    <= '0;
            r_found      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cfg_rgb[i] <= '0;
                r_cfg_thr[i] <= '0;
                r_sh_rgb[i]  <= '0;
                r_sh_thr[i]  <= '0;
                r_hit_x[i]   <= '0;
                r_hit_y[i]   <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cfg_rgb[i] <= w_cfg_rgb_nxt[i];
                r_cfg_thr[i] <= w_cfg_thr_nxt[i];
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    // busy drops the cycle after frame_done.
                    if (r_state == S_DONE) r_busy <= 1'b0;
                    if (w_start_acc) begin
                        r_busy  <= 1'b1;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_found <= '0;
                        for (int i = 0; i < 4; i++) begin
                            r_sh_rgb[i] <= w_cfg_rgb_nxt[i];
                            r_sh_thr[i] <= w_cfg_thr_nxt[i];
                            r_hit_x[i]  <= '0;
                            r_hit_y[i]  <= '0;
                        end
                    end
                end

                S_WAIT_PIX: begin
                    if (bus.pix_valid) begin
                        r_pix  <= {bus.pix_r, bus.pix_g, bus.pix_b};
                        r_slot <= '0;
                    end
                end

                S_EVAL: begin
                    r_det_tgt <= w_cur_tgt;
                    r_det_thr <= w_cur_thr;
                    // First match per slot wins; later hits leave the position alone.
                    if (bus.det_hit && !r_found[r_slot]) begin
                        r_found[r_slot] <= 1'b1;
                        r_hit_x[r_slot] <= r_x;
                        r_hit_y[r_slot] <= r_y;
                    end
                    r_slot <= r_slot + 2'd1;
                    if (w_last_slot) begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= (r_y == Y_LAST) ? 10'd0 : r_y + 10'd1;
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                        if (w_last_pix) r_frame_done <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_corner_scan_ctrl.sv
// Purpose : self-checking bench for corner_scan_ctrl on a 4x2 frame with a behavioural detector.
// Latency : checks 5-cycle pixel cadence and single-cycle frame_done.
// Backpr. : drives pix_valid with optional random gaps; holds it until pix_ready.
module tb_corner_scan_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int TW = 10;

    typedef logic [7:0][23:0] frame_t;

    typedef struct {
        logic [3:0][23:0]   tgt;
        logic [3:0][TW-1:0] thr;
        frame_t             pix;
        bit                 stall;
        logic [3:0]         e_found;
        logic [39:0]        e_x;
        logic [39:0]        e_y;
    } vec_t;

    logic clk_50 = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs [5];

    corner_scan_ctrl_if #(.THRESH_W(TW)) bus ();

    corner_scan_ctrl #(.H_RES(H), .V_RES(V), .THRESH_W(TW)) dut (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;

    // Detector model: sum of absolute channel differences strictly below threshold.
    int   dr, dg, db;
    logic w_hit;
    always_comb begin
        dr = int'(bus.det_r) - int'(bus.det_rgb_target[23:16]);
        dg = int'(bus.det_g) - int'(bus.det_rgb_target[15:8]);
        db = int'(bus.det_b) - int'(bus.det_rgb_target[7:0]);
        if (dr < 0) dr = -dr;
        if (dg < 0) dg = -dg;
        if (db < 0) db = -db;
        w_hit = ((dr + dg + db) < int'(bus.det_threshold));
    end
    assign bus.det_hit = w_hit;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [23:0] rgb, input logic [TW-1:0] thr);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = idx;
        bus.cfg_rgb    = rgb;
        bus.cfg_thresh = thr;
        tick();
        bus.cfg_we     = 1'b0;
    endtask

    task automatic start_frame(input string nm);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({nm, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic feed_pixel(input string nm, input logic [23:0] px, input bit stall, input bit last);
        int cnt;
        int n;
        if (stall) begin
            n = int'($urandom_range(0, 3));
            bus.pix_valid = 1'b0;
            repeat (n) tick();
        end
        bus.pix_r     = px[23:16];
        bus.pix_g     = px[15:8];
        bus.pix_b     = px[7:0];
        bus.pix_valid = 1'b1;
        cnt = 0;
        while (!bus.pix_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        if (cnt >= 20) check({nm, "_ready_timeout"}, 64'd0, 64'd1);
        tick();
        bus.pix_valid = 1'b0;
        if (!last) begin
            cnt = 0;
            while (!bus.pix_ready && cnt < 20) begin
                cnt++;
                tick();
            end
            check({nm, "_ready_low_cycles"}, 64'(cnt), 64'd4);
        end
    endtask

    task automatic finish_frame(input string nm, input logic [3:0] ef, input logic [39:0] ex, input logic [39:0] ey);
        int fd;
        bit done;
        fd   = 0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            if (bus.frame_done) fd++;
            if (fd > 0 && !bus.busy) done = 1'b1;
            else tick();
        end
        check({nm, "_done_pulses"}, 64'(fd), 64'd1);
        check({nm, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({nm, "_found"}, 64'(bus.found), 64'(ef));
        check({nm, "_hit_x"}, 64'(bus.hit_x), 64'(ex));
        check({nm, "_hit_y"}, 64'(bus.hit_y), 64'(ey));
    endtask

    task automatic cfg_vec(input int v);
        for (int s = 0; s < 4; s++) cfg_write(2'(s), vecs[v].tgt[s], vecs[v].thr[s]);
    endtask

    task automatic run_vec(input int v);
        string nm;
        nm = $sformatf("vec%0d", v);
        cfg_vec(v);
        start_frame(nm);
        for (int p = 0; p < 8; p++) feed_pixel(nm, vecs[v].pix[p], vecs[v].stall, p == 7);
        finish_frame(nm, vecs[v].e_found, vecs[v].e_x, vecs[v].e_y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        frame_t f;
        int fd;

        // 0: single near-red pixel at (2,1)
        vecs[0].tgt = {24'h0, 24'h0, 24'h0, 24'hFF0000};
        vecs[0].thr = {10'd0, 10'd0, 10'd0, 10'd2};
        vecs[0].pix = '0; vecs[0].pix[6] = 24'hFE0000;
        vecs[0].stall = 1'b0; vecs[0].e_found = 4'b0001;
        vecs[0].e_x = {10'd0, 10'd0, 10'd0, 10'd2};
        vecs[0].e_y = {10'd0, 10'd0, 10'd0, 10'd1};
        // 1: two slots share a colour; both record the first match (1,0)
        vecs[1].tgt = {24'h0, 24'h0, 24'hFF0000, 24'hFF0000};
        vecs[1].thr = {10'd0, 10'd0, 10'd2, 10'd2};
        vecs[1].pix = '0; vecs[1].pix[1] = 24'hFF0000; vecs[1].pix[7] = 24'hFF0000;
        vecs[1].stall = 1'b0; vecs[1].e_found = 4'b0011;
        vecs[1].e_x = {10'd0, 10'd0, 10'd1, 10'd1};
        vecs[1].e_y = {10'd0, 10'd0, 10'd0, 10'd0};
        // 2: three distinct slots hit at different positions, slot0 never
        vecs[2].tgt = {24'h191919, 24'h0000FF, 24'h00FF00, 24'hFF0000};
        vecs[2].thr = {10'd5, 10'd2, 10'd2, 10'd2};
        vecs[2].pix = '0; vecs[2].pix[0] = 24'h0000FF; vecs[2].pix[3] = 24'h00FF00;
        vecs[2].pix[5] = 24'h1A1A1A;
        vecs[2].stall = 1'b0; vecs[2].e_found = 4'b1110;
        vecs[2].e_x = {10'd1, 10'd0, 10'd3, 10'd0};
        vecs[2].e_y = {10'd1, 10'd0, 10'd0, 10'd0};
        // 3: same as 1 but with random pix_valid gaps
        vecs[3] = vecs[1];
        vecs[3].stall = 1'b1;
        // 4: match only on the very last pixel (3,1)
        vecs[4].tgt = {24'h00FF00, 24'h0, 24'h0, 24'h0};
        vecs[4].thr = {10'd3, 10'd0, 10'd0, 10'd0};
        vecs[4].pix = '0; vecs[4].pix[7] = 24'h00FF00;
        vecs[4].stall = 1'b0; vecs[4].e_found = 4'b1000;
        vecs[4].e_x = {10'd3, 30'd0};
        vecs[4].e_y = {10'd1, 30'd0};

        reset = 1'b1;
        bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_rgb = '0;
        bus.cfg_thresh = '0; bus.pix_valid = 1'b0;
        bus.pix_r = '0; bus.pix_g = '0; bus.pix_b = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_frame_done", 64'(bus.frame_done), 64'd0);
        check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
        check("rst_found", 64'(bus.found), 64'd0);
        check("rst_hit_xy", {bus.hit_y[23:0], bus.hit_x}, 64'd0);
        check("rst_det", {bus.det_threshold, bus.det_rgb_target, bus.det_r, bus.det_g, bus.det_b}, 64'd0);

        for (int v = 0; v < 5; v++) run_vec(v);

        // Mid-frame slot2 write only takes effect next frame; a write in
        // the start cycle (slot3) is included in that frame's copy.
        cfg_write(2'd0, 24'hFF0000, 10'd2);
        cfg_write(2'd1, 24'h0, 10'd0);
        cfg_write(2'd2, 24'h0, 10'd0);
        cfg_write(2'd3, 24'h0, 10'd0);
        f = '0; f[4] = 24'h191919;
        start_frame("midcfg_a");
        for (int p = 0; p < 8; p++) begin
            if (p == 2) cfg_write(2'd2, 24'h191919, 10'd5);
            feed_pixel("midcfg_a", f[p], 1'b0, p == 7);
        end
        finish_frame("midcfg_a", 4'b0000, 40'd0, 40'd0);
        bus.start = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_idx = 2'd3; bus.cfg_rgb = 24'h191919; bus.cfg_thresh = 10'd5;
        tick();
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        for (int p = 0; p < 8; p++) feed_pixel("midcfg_b", f[p], 1'b0, p == 7);
        finish_frame("midcfg_b", 4'b1100, 40'd0, {10'd1, 10'd1, 20'd0});

        // Start pulse during a scan is ignored.
        cfg_vec(0);
        start_frame("midstart");
        for (int p = 0; p < 8; p++) begin
            if (p == 3) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
            end
            feed_pixel("midstart", vecs[0].pix[p], 1'b0, p == 7);
        end
        finish_frame("midstart", vecs[0].e_found, vecs[0].e_x, vecs[0].e_y);

        // Reset after five pixels clears results, no frame_done follows.
        cfg_vec(1);
        start_frame("midrst");
        for (int p = 0; p < 5; p++) feed_pixel("midrst", vecs[1].pix[p], 1'b0, 1'b0);
        check("midrst_found_before", 64'(bus.found), 64'b0011);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_found", 64'(bus.found), 64'd0);
        check("midrst_hit_x", 64'(bus.hit_x), 64'd0);
        check("midrst_pix_ready", 64'(bus.pix_ready), 64'd0);
        fd = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.frame_done) fd++;
            tick();
        end
        check("midrst_no_done", 64'(fd), 64'd0);
        run_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
